avl_read_cache: RTL and testbench
=================================

Name: avl_read_cache

Overview:
- Direct-mapped, one-word-per-line cache between the `harvard_to_avalon` bridge's Avalon master port and the Avalon memory slave. It sits downstream of the bridge and upstream of memory.
- Reads are read-allocate. Writes are write-through with no-allocate.
- The MIPS kseg1 region (address[31:29]==3'b101, which contains reset vector 0xBFC00000) is never cached and is passed straight through.
- Removes bus wait cycles from repeated instruction and data fetches without changing Avalon semantics on either side.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines); index = address[INDEX_BITS+1:2], tag = address[31:INDEX_BITS+2].
- BYPASS_KSEG1, 1, when 1, accesses with address[31:29]==3'b101 bypass the cache; when 0, every address is cacheable.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_address  input  32  upstream byte address.
- s_byteenable  input  4  upstream byte lanes.
- s_writedata  input  32  upstream write data.
- s_read  input  1  upstream read request.
- s_write  input  1  upstream write request.
- s_readdata  output  32  read data, valid in the cycle s_read=1 and s_waitrequest=0.
- s_waitrequest  output  1  upstream stall.
- m_address  output  32  downstream address, bits[1:0] always 0.
- m_byteenable  output  4  downstream byte lanes.
- m_writedata  output  32  downstream write data.
- m_read  output  1  downstream read.
- m_write  output  1  downstream write.
- m_readdata  input  32  downstream data, valid in the cycle m_read=1 and m_waitrequest=0.
- m_waitrequest  input  1  downstream stall.

Behaviour:
- Avalon rules, both sides:
  - A transfer completes on a rising edge where the request is high and waitrequest is low.
  - A master holds address, data, byteenable and request stable while waitrequest is high.
  - Read latency is 0 (data arrives in the completing cycle).
- Storage: per line, a valid bit, a tag and 32 bits of data. All valid bits clear on reset; data and tag are not reset.
- State machine: IDLE, FILL, BYP_RD, WR, RESP.
- IDLE, no request: s_waitrequest=0; m_read=0; m_write=0.
- IDLE, s_read, cacheable hit (valid and tag match):
  - s_waitrequest=0 combinationally; s_readdata = line data, all 4 bytes regardless of byteenable.
  - Stay in IDLE. Zero-wait hit; back-to-back hits give one word per cycle.
- IDLE, s_read, cacheable miss: s_waitrequest=1; go to FILL.
- FILL:
  - Drive m_read=1, m_address={s_address[31:2],2'b00}, m_byteenable=4'b1111.
  - On the cycle m_waitrequest=0: write data, tag and valid into the line, capture data into a response register, go to RESP.
- IDLE, s_read, bypass address: s_waitrequest=1; go to BYP_RD.
- BYP_RD:
  - Drive m_read=1 and m_byteenable=s_byteenable.
  - On completion: capture data, do not touch the cache, go to RESP.
- IDLE, s_write (any address): s_waitrequest=1; go to WR.
- WR:
  - Drive m_write=1 with s_address (aligned), s_byteenable and s_writedata.
  - On completion: if the address is cacheable and hits, merge the enabled bytes into the line. Misses are not allocated.
  - Go to RESP.
- RESP:
  - s_waitrequest=0 for exactly one cycle; s_readdata = response register.
  - m_read=0; m_write=0. Return to IDLE.
  - Upstream request must still be held here (Avalon hold rule).
- Miss and bypass latency: request seen in IDLE at cycle 0, m_read high from cycle 1, completion at cycle k, s_waitrequest low at cycle k+1. Zero memory wait gives 2 stall cycles.
- Simultaneous s_read and s_write: illegal upstream; write takes priority and the read is ignored.
- s_readdata outside valid cycles: don't-care, but must not be X in simulation (drive the response register).
- While rst=1:
  - s_waitrequest=1; m_read=0; m_write=0; m_address=0; m_byteenable=0; m_writedata=0; s_readdata=0.
  - Next state is IDLE with all lines invalid.
- Reset mid-FILL/WR/BYP_RD: the transfer is abandoned and m_read/m_write are low in the cycle after the reset edge. A pending upstream request restarts from IDLE after rst falls.
- Index wrap: addresses differing only above bit INDEX_BITS+1 alias to the same line and evict each other.

Test Plan:
- Memory preloaded at 0x10 with 0xCAFEF00D, m_waitrequest low after 2 cycles. Read 0x10, then read 0x10 again:
  - First read: one m_read at m_address 0x10 with byteenable 1111; s_readdata 0xCAFEF00D after 4 stall cycles.
  - Second read: s_waitrequest=0 in the request cycle, no m_read.
- Read 0xBFC00000 twice, byteenable 4'b1000 → two separate m_read transfers, each with m_byteenable 4'b1000; no line allocated.
- Read 0x0 (holds 0x12345678, now cached), then write 0xDDCCBBAA to 0x0 with byteenable 0001 → one m_write with byteenable 0001; the following read of 0x0 is a hit returning 0x123456AA.
- INDEX_BITS=4: read 0x0, then 0x40, then 0x0 → three m_read transfers (conflict eviction).
- Write 0x80 (miss), then read 0x80 → m_write then m_read; the read is a miss (no-allocate).
- Start a miss on 0x20 with m_waitrequest held high, then assert rst for 1 cycle → m_read low the next cycle. After reset, a read of any previously cached address misses; a held read of 0x20 completes normally.

Source files
------------

// File: rtl/avl_read_cache.sv
// Direct-mapped, one-word-per-line read cache placed between an Avalon master and memory.
// Reads allocate. Writes go straight through and are not allocated. kseg1 can be made uncached.
module avl_read_cache #(
    parameter int INDEX_BITS   = 4,
    parameter bit BYPASS_KSEG1 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_address,
    input  logic [3:0]  s_byteenable,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic [31:0] m_address,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, FILL, BYP_RD, WR, RESP} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem [LINES];
    logic [31:0]             data_mem [LINES];
    logic [31:0]             resp_data;

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    cacheable;
    logic                    hit;
    logic [31:0]             line_data;
    logic                    fill_we;
    logic                    merge_we;
    logic                    unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    assign idx              = s_address[INDEX_BITS+1:2];
    assign tag              = s_address[31:INDEX_BITS+2];
    assign unused_addr_bits = ^s_address[1:0];
    assign cacheable        = !(BYPASS_KSEG1 && (s_address[31:29] == 3'b101));
    assign line_data        = data_mem[idx];
    // An invalid line short-circuits the compare, so unreset tags never leak X.
    assign hit              = cacheable && valid[idx] && (tag_mem[idx] == tag);

    assign fill_we  = !rst && (state == FILL) && !m_waitrequest;
    assign merge_we = !rst && (state == WR) && !m_waitrequest && hit;

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[idx] <= m_readdata;
            tag_mem[idx]  <= tag;
        end else if (merge_we) begin
            data_mem[idx] <= merge_bytes(line_data, s_writedata, s_byteenable);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_write)
                        state <= WR;
                    else if (s_read && !cacheable)
                        state <= BYP_RD;
                    else if (s_read && !hit)
                        state <= FILL;
                end
                FILL: begin
                    if (!m_waitrequest) begin
                        valid[idx] <= 1'b1;
                        resp_data  <= m_readdata;
                        state      <= RESP;
                    end
                end
                BYP_RD: begin
                    if (!m_waitrequest) begin
                        resp_data <= m_readdata;
                        state     <= RESP;
                    end
                end
                WR: begin
                    if (!m_waitrequest)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream signals follow the held upstream request; reset forces everything quiet.
    always_comb begin
        s_waitrequest = 1'b1;
        s_readdata    = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_address     = '0;
        m_byteenable  = '0;
        m_writedata   = '0;
        if (!rst) begin
            m_address    = {s_address[31:2], 2'b00};
            m_byteenable = s_byteenable;
            m_writedata  = s_writedata;
            s_readdata   = resp_data;
            case (state)
                IDLE: begin
                    s_waitrequest = s_write || (s_read && !hit);
                    if (hit)
                        s_readdata = line_data;
                end
                FILL: begin
                    m_read       = 1'b1;
                    m_byteenable = 4'b1111;
                end
                BYP_RD:  m_read = 1'b1;
                WR:      m_write = 1'b1;
                RESP:    s_waitrequest = 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_avl_read_cache.sv
// Scoreboard bench for avl_read_cache: read data is queued when a read is issued and
// compared when the cache releases it; a memory model counts downstream transfers.
module tb_avl_read_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_address = '0;
    logic [3:0]  s_byteenable = '0;
    logic [31:0] s_writedata = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic [31:0] m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_readdata;
    logic        m_waitrequest;

    always #5 clk = ~clk;

    avl_read_cache #(.INDEX_BITS(4), .BYPASS_KSEG1(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_read(m_read), .m_write(m_write), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];

    // Memory model: mem_wait stall cycles per transfer, hold_wait stalls indefinitely.
    logic [31:0] mem [64];
    logic [31:0] kseg_word;
    int          mem_wait = 2;
    bit          hold_wait = 1'b0;
    int          wait_cnt = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    logic [31:0] last_addr = '0;
    logic [3:0]  last_be = '0;

    assign m_waitrequest = hold_wait || (wait_cnt < mem_wait);
    assign m_readdata    = (m_address[31:29] == 3'b101) ? kseg_word : mem[m_address[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]         <= 32'h12345678;
            mem[32'h10>>2] <= 32'hCAFEF00D;
            mem[32'h20>>2] <= 32'h20202020;
            mem[32'h40>>2] <= 32'h44444444;
            mem[32'h80>>2] <= 32'h80808080;
            kseg_word      <= 32'hAABBCCDD;
            wait_cnt       <= 0;
        end else if (m_read || m_write) begin
            if (!m_waitrequest) begin
                wait_cnt  <= 0;
                last_addr <= m_address;
                last_be   <= m_byteenable;
                if (m_read) rd_count <= rd_count + 1;
                if (m_write) begin
                    wr_count <= wr_count + 1;
                    for (int b = 0; b < 4; b++)
                        if (m_byteenable[b])
                            mem[m_address[7:2]][8*b +: 8] <= m_writedata[8*b +: 8];
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered just after a falling edge with the request already driven.
    task automatic wait_done(input string tag, input bit is_rd, output int stalls);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!s_waitrequest) begin
                if (is_rd) check_eq({tag, "_data"}, s_readdata, exp_q.pop_front());
                @(posedge clk);
                return;
            end
            stalls++;
            @(negedge clk);
        end
        if (is_rd) void'(exp_q.pop_front());
        check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] exp, input int exp_stalls);
        int st;
        @(negedge clk);
        s_address = addr; s_byteenable = be; s_read = 1'b1; s_write = 1'b0;
        exp_q.push_back(exp);
        wait_done(tag, 1'b1, st);
        check_eq({tag, "_stalls"}, 32'(st), 32'(exp_stalls));
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data);
        int st;
        @(negedge clk);
        s_address = addr; s_byteenable = be; s_writedata = data; s_read = 1'b0; s_write = 1'b1;
        wait_done(tag, 1'b0, st);
    endtask

    task automatic go_idle();
        @(negedge clk);
        s_read = 1'b0; s_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, st;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_eq("rst_waitreq", 32'(s_waitrequest), 32'd1);
        check_eq("rst_mread", 32'(m_read), 32'd0);
        check_eq("rst_mwrite", 32'(m_write), 32'd0);
        check_eq("rst_maddr", m_address, 32'h0);
        check_eq("rst_rdata", s_readdata, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        check_eq("idle_waitreq", 32'(s_waitrequest), 32'd0);
        check_eq("idle_mread", 32'(m_read), 32'd0);

        // Miss then hit on 0x10
        rd0 = rd_count;
        do_read("miss10", 32'h10, 4'hF, 32'hCAFEF00D, 4);
        check_eq("miss10_mreads", 32'(rd_count - rd0), 32'd1);
        check_eq("miss10_maddr", last_addr, 32'h10);
        check_eq("miss10_mbe", 32'(last_be), 32'hF);
        rd0 = rd_count;
        do_read("hit10", 32'h10, 4'hF, 32'hCAFEF00D, 0);
        check_eq("hit10_mreads", 32'(rd_count - rd0), 32'd0);

        // kseg1 bypass never allocates
        for (int k = 0; k < 2; k++) begin
            rd0 = rd_count;
            do_read("kseg1", 32'hBFC00000, 4'b1000, 32'hAABBCCDD, 4);
            check_eq("kseg1_mreads", 32'(rd_count - rd0), 32'd1);
            check_eq("kseg1_maddr", last_addr, 32'hBFC00000);
            check_eq("kseg1_mbe", 32'(last_be), 32'b1000);
        end

        // Write-through hit merges the enabled byte into the line
        do_read("miss0", 32'h0, 4'hF, 32'h12345678, 4);
        wr0 = wr_count;
        do_write("wr0", 32'h0, 4'b0001, 32'hDDCCBBAA);
        check_eq("wr0_mwrites", 32'(wr_count - wr0), 32'd1);
        check_eq("wr0_mbe", 32'(last_be), 32'b0001);
        check_eq("wr0_maddr", last_addr, 32'h0);
        do_read("hit0_merged", 32'h0, 4'hF, 32'h123456AA, 0);

        // 0x40 aliases with 0x0 on a 16-line cache
        rd0 = rd_count;
        do_read("conflict40", 32'h40, 4'hF, 32'h44444444, 4);
        do_read("evicted0", 32'h0, 4'hF, 32'h123456AA, 4);
        check_eq("conflict_mreads", 32'(rd_count - rd0), 32'd2);

        // Write miss does not allocate
        wr0 = wr_count;
        rd0 = rd_count;
        do_write("wr80", 32'h80, 4'hF, 32'h11112222);
        do_read("rd80", 32'h80, 4'hF, 32'h11112222, 4);
        check_eq("wr80_mwrites", 32'(wr_count - wr0), 32'd1);
        check_eq("rd80_mreads", 32'(rd_count - rd0), 32'd1);
        go_idle();

        // Reset in the middle of a stalled fill
        hold_wait = 1'b1;
        @(negedge clk);
        s_address = 32'h20; s_byteenable = 4'hF; s_read = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("stall_mread", 32'(m_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("midrst_mread", 32'(m_read), 32'd0);
        check_eq("midrst_waitreq", 32'(s_waitrequest), 32'd1);
        check_eq("midrst_mbe", 32'(m_byteenable), 32'd0);
        rst = 1'b0;
        hold_wait = 1'b0;
        #1;
        check_eq("postrst_mread", 32'(m_read), 32'd0);
        exp_q.push_back(32'h20202020);
        wait_done("held20", 1'b1, st);
        check_eq("held20_stalls", 32'(st), 32'd4);
        rd0 = rd_count;
        do_read("postrst10", 32'h10, 4'hF, 32'hCAFEF00D, 4);
        check_eq("postrst10_mreads", 32'(rd_count - rd0), 32'd1);
        go_idle();

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
